uart_rx_param: RTL and testbench

- Parametrised UART receiver. It is the next generation of the fixed 8N1 receive path inside uart_loop.
- Synchronises the serial line and oversamples it 16x, taking a majority vote at mid-bit.
- Supports configurable data width, parity mode and stop-bit count. Reports parity, framing and overrun errors.
- Delivers each received word over a valid/ready handshake to the downstream TX or loopback logic.

---
 rtl/uart_rx_param.sv | 186 ++++++++++++++++++
 tb/tb_uart_rx_param.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// uart_rx_param
// Parametrised UART receiver with 16x oversampling and a mid-bit majority vote.
// It checks for parity, framing and overrun errors, and hands each received
// word to the consumer over a valid/ready handshake.
//
// Ports:
//   i_clk_sys     system clock; all logic runs on the rising edge
//   i_rst         asynchronous active-high reset
//   i_uart_rx     serial line; idles high; asynchronous to i_clk_sys
//   o_data        received word; the LSB is the first bit on the line
//   o_valid       o_data and the error flags are valid
//   i_ready       consumer takes the word when o_valid && i_ready
//   o_parity_err  parity mismatch on the presented word
//   o_frame_err   a stop bit of the presented word was sampled low
//   o_overrun     one-cycle pulse: a frame was dropped because the output was full
//   o_busy        receiver FSM is not in IDLE
module uart_rx_param #(
  parameter int CLK_FREQ    = 50000000,
  parameter int BAUD        = 9600,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 i_clk_sys,
  input  logic                 i_rst,
  input  logic                 i_uart_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_overrun,
  output logic                 o_busy
);

  localparam int              OS_DIV    = CLK_FREQ / (BAUD * 16);
  localparam int              OS_W      = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;
  localparam logic [OS_W-1:0] OS_LAST   = OS_W'(OS_DIV - 1);
  localparam logic [3:0]      LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]      LAST_STOP = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                 state_q, state_d;
  logic                   rx_meta, rx_sync, rx_prev;
  logic [OS_W-1:0]        os_cnt;
  logic [3:0]             s_cnt;
  logic [3:0]             bit_cnt;
  logic                   smp7, smp8;
  logic [DATA_BITS-1:0]   shift_q;
  logic                   par_err_q, frame_acc;
  logic                   commit_d, commit_q;
  logic                   tick, fall, vote, vote_tick, boundary;

  assign tick      = (os_cnt == OS_LAST);
  assign fall      = rx_prev & ~rx_sync;
  assign vote_tick = tick && (s_cnt == 4'd9);
  assign boundary  = tick && (s_cnt == 4'd15);
  // Two-of-three vote. Samples 7 and 8 are held in flops. Sample 9 is the live line.
  assign vote      = (smp7 & smp8) | (smp7 & rx_sync) | (smp8 & rx_sync);
  assign o_busy    = (state_q != IDLE);

  // The synchroniser and the edge-detect history reset to the idle-line level,
  // so reset cannot produce a false falling edge.
  always_ff @(posedge i_clk_sys or posedge i_rst) begin
    if (i_rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= i_uart_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // The oversample tick is free-running, so the start edge sees up to one tick of phase jitter.
  always_ff @(posedge i_clk_sys or posedge i_rst) begin
    if (i_rst) os_cnt <= '0;
    else if (tick) os_cnt <= '0;
    else os_cnt <= os_cnt + 1'b1;
  end

  // The sample counter stays at zero in IDLE, so every frame starts counting from 0.
  always_ff @(posedge i_clk_sys or posedge i_rst) begin
    if (i_rst) s_cnt <= '0;
    else if (state_q == IDLE) s_cnt <= '0;
    else if (tick) s_cnt <= s_cnt + 1'b1;
  end

  always_ff @(posedge i_clk_sys or posedge i_rst) begin
    if (i_rst) state_q <= IDLE;
    else state_q <= state_d;
  end

  // The last stop bit commits at its vote instead of its end,
  // so a start edge that follows it directly is still caught.
  always_comb begin
    state_d  = state_q;
    commit_d = 1'b0;
    case (state_q)
      IDLE:   if (fall) state_d = START;
      START: begin
        if (vote_tick && vote) state_d = IDLE;
        else if (boundary) state_d = DATA;
      end
      DATA:   if (boundary && bit_cnt == LAST_DATA)
                state_d = (PARITY_MODE != 0) ? PARITY : STOP;
      PARITY: if (boundary) state_d = STOP;
      STOP: begin
        if (vote_tick && bit_cnt == LAST_STOP) begin
          state_d  = IDLE;
          commit_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bit datapath. bit_cnt is reused: it counts data bits, then stop bits.
  // It returns to 0 when the data phase ends.
  always_ff @(posedge i_clk_sys or posedge i_rst) begin
    if (i_rst) begin
      smp7      <= 1'b1;
      smp8      <= 1'b1;
      shift_q   <= '0;
      bit_cnt   <= '0;
      par_err_q <= 1'b0;
      frame_acc <= 1'b0;
      commit_q  <= 1'b0;
    end else begin
      commit_q <= commit_d;
      if (tick && s_cnt == 4'd7) smp7 <= rx_sync;
      if (tick && s_cnt == 4'd8) smp8 <= rx_sync;
      case (state_q)
        IDLE: begin
          if (fall) begin
            bit_cnt   <= '0;
            par_err_q <= 1'b0;
            frame_acc <= 1'b0;
          end
        end
        DATA: begin
          if (vote_tick) shift_q <= {vote, shift_q[DATA_BITS-1:1]};
          if (boundary) bit_cnt <= (bit_cnt == LAST_DATA) ? 4'd0 : bit_cnt + 4'd1;
        end
        PARITY: begin
          if (vote_tick)
            par_err_q <= (PARITY_MODE == 2) ? ~(^shift_q ^ vote) : (^shift_q ^ vote);
        end
        STOP: begin
          if (vote_tick && !vote) frame_acc <= 1'b1;
          if (boundary) bit_cnt <= bit_cnt + 4'd1;
        end
        default: ;
      endcase
    end
  end

  // Output register. A commit takes precedence over a same-cycle acceptance.
  // A commit into a full register that is not being accepted is dropped.
  always_ff @(posedge i_clk_sys or posedge i_rst) begin
    if (i_rst) begin
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      o_overrun <= 1'b0;
      if (commit_q) begin
        if (!o_valid || i_ready) begin
          o_data       <= shift_q;
          o_parity_err <= par_err_q;
          o_frame_err  <= frame_acc;
          o_valid      <= 1'b1;
        end else begin
          o_overrun <= 1'b1;
        end
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param
// Directed test of uart_rx_param. There are three instances:
//   0: 8N1
//   1: 7 data bits, even parity, 1 stop bit
//   2: 8 data bits, no parity, 2 stop bits
// A small clock/baud ratio gives OS_DIV=4, so one bit lasts 64 clocks.
module tb_uart_rx_param;

  localparam int CLK_FREQ = 1000000;
  localparam int BAUD     = 15625;
  localparam int BIT      = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] rx_line = 3'b111;
  logic [2:0] ready = 3'b000;
  wire  [2:0] valid, pe, fe, ov, busy;
  wire  [7:0] data0, data2;
  wire  [6:0] data1;

  int total = 0;
  int bad   = 0;
  int ov_cyc [3] = '{0, 0, 0};
  int v_rise [3] = '{0, 0, 0};
  logic [2:0] v_prev = 3'b000;
  int ov_base, vr_base;

  always #5 clk = ~clk;

  uart_rx_param #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut0 (
    .i_clk_sys(clk), .i_rst(rst), .i_uart_rx(rx_line[0]), .o_data(data0),
    .o_valid(valid[0]), .i_ready(ready[0]), .o_parity_err(pe[0]),
    .o_frame_err(fe[0]), .o_overrun(ov[0]), .o_busy(busy[0]));

  uart_rx_param #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(7), .PARITY_MODE(1)) dut1 (
    .i_clk_sys(clk), .i_rst(rst), .i_uart_rx(rx_line[1]), .o_data(data1),
    .o_valid(valid[1]), .i_ready(ready[1]), .o_parity_err(pe[1]),
    .o_frame_err(fe[1]), .o_overrun(ov[1]), .o_busy(busy[1]));

  uart_rx_param #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .STOP_BITS(2)) dut2 (
    .i_clk_sys(clk), .i_rst(rst), .i_uart_rx(rx_line[2]), .o_data(data2),
    .o_valid(valid[2]), .i_ready(ready[2]), .o_parity_err(pe[2]),
    .o_frame_err(fe[2]), .o_overrun(ov[2]), .o_busy(busy[2]));

  // Count the cycles o_overrun is high and the rising edges of o_valid for each instance.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (ov[i]) ov_cyc[i]++;
      if (valid[i] && !v_prev[i]) v_rise[i]++;
    end
    v_prev <= valid;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive n frame bits, LSB first, one bit time each. Then return the line to idle.
  task automatic applyStimulus(input int which, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      rx_line[which] = bits[i];
      repeat (BIT) @(negedge clk);
    end
    rx_line[which] = 1'b1;
  endtask

  task automatic waitValid(input int which, input string tag);
    int n = 0;
    while (valid[which] !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, 32'(valid[which]), 32'd1);
  endtask

  task automatic ackWord(input int which, input string tag);
    ready[which] = 1'b1;
    @(negedge clk);
    ready[which] = 1'b0;
    checkOutput(tag, 32'(valid[which]), 32'd0);
  endtask

  initial begin
    // Check the state during reset.
    repeat (5) @(negedge clk);
    checkOutput("rst_valid", 32'(valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_data0", 32'(data0), 32'd0);
    checkOutput("rst_ovr", 32'(ov), 32'd0);
    rst = 1'b0;
    repeat (2 * BIT) @(negedge clk);

    // 8N1: receive 0xAC.
    ov_base = ov_cyc[0];
    vr_base = v_rise[0];
    applyStimulus(0, {6'd0, 1'b1, 8'hAC, 1'b0}, 10);
    waitValid(0, "ac_valid");
    checkOutput("ac_data", 32'(data0), 32'hAC);
    checkOutput("ac_perr", 32'(pe[0]), 32'd0);
    checkOutput("ac_ferr", 32'(fe[0]), 32'd0);
    ackWord(0, "ac_ack");
    repeat (BIT) @(negedge clk);
    checkOutput("ac_pulses", 32'(v_rise[0] - vr_base), 32'd1);
    checkOutput("ac_ovr", 32'(ov_cyc[0] - ov_base), 32'd0);

    // 7E1: 0x55 has four ones, so parity bit 0 is correct and parity bit 1 is wrong.
    applyStimulus(1, {6'd0, 1'b1, 1'b0, 7'h55, 1'b0}, 10);
    waitValid(1, "p0_valid");
    checkOutput("p0_data", 32'(data1), 32'h55);
    checkOutput("p0_perr", 32'(pe[1]), 32'd0);
    checkOutput("p0_ferr", 32'(fe[1]), 32'd0);
    ackWord(1, "p0_ack");
    repeat (BIT) @(negedge clk);
    applyStimulus(1, {6'd0, 1'b1, 1'b1, 7'h55, 1'b0}, 10);
    waitValid(1, "p1_valid");
    checkOutput("p1_data", 32'(data1), 32'h55);
    checkOutput("p1_perr", 32'(pe[1]), 32'd1);
    checkOutput("p1_ferr", 32'(fe[1]), 32'd0);
    ackWord(1, "p1_ack");

    // 8N2: the second stop bit is low, then a clean 0x81 follows.
    applyStimulus(2, {5'd0, 1'b0, 1'b1, 8'h3C, 1'b0}, 11);
    waitValid(2, "s2_valid");
    checkOutput("s2_data", 32'(data2), 32'h3C);
    checkOutput("s2_ferr", 32'(fe[2]), 32'd1);
    ackWord(2, "s2_ack");
    repeat (BIT) @(negedge clk);
    applyStimulus(2, {5'd0, 1'b1, 1'b1, 8'h81, 1'b0}, 11);
    waitValid(2, "s2b_valid");
    checkOutput("s2b_data", 32'(data2), 32'h81);
    checkOutput("s2b_ferr", 32'(fe[2]), 32'd0);
    ackWord(2, "s2b_ack");

    // Overrun: send two frames back-to-back while the consumer is not ready.
    repeat (BIT) @(negedge clk);
    ov_base = ov_cyc[0];
    vr_base = v_rise[0];
    applyStimulus(0, {6'd0, 1'b1, 8'h11, 1'b0}, 10);
    applyStimulus(0, {6'd0, 1'b1, 8'h22, 1'b0}, 10);
    repeat (4) @(negedge clk);
    checkOutput("ovr_valid", 32'(valid[0]), 32'd1);
    checkOutput("ovr_data", 32'(data0), 32'h11);
    checkOutput("ovr_cycles", 32'(ov_cyc[0] - ov_base), 32'd1);
    ackWord(0, "ovr_ack");
    repeat (3 * BIT) @(negedge clk);
    checkOutput("ovr_nodrop", 32'(valid[0]), 32'd0);
    checkOutput("ovr_pulses", 32'(v_rise[0] - vr_base), 32'd1);

    // Glitch: a short low pulse starts the FSM, then the start-bit vote rejects it.
    vr_base = v_rise[0];
    rx_line[0] = 1'b0;
    repeat (8) @(negedge clk);
    rx_line[0] = 1'b1;
    repeat (6) @(negedge clk);
    checkOutput("gl_busy_on", 32'(busy[0]), 32'd1);
    repeat (BIT) @(negedge clk);
    checkOutput("gl_busy_off", 32'(busy[0]), 32'd0);
    checkOutput("gl_novalid", 32'(v_rise[0] - vr_base), 32'd0);
    applyStimulus(0, {6'd0, 1'b1, 8'h5A, 1'b0}, 10);
    waitValid(0, "gl_valid");
    checkOutput("gl_data", 32'(data0), 32'h5A);
    checkOutput("gl_ferr", 32'(fe[0]), 32'd0);

    // Reset in data bit 4 while a word is held: outputs clear at once.
    // The next frame is clean.
    rx_line[0] = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx_line[0] = (i % 2 == 0);
      repeat (BIT) @(negedge clk);
    end
    rx_line[0] = 1'b0;
    repeat (BIT / 2) @(negedge clk);
    checkOutput("mr_busy_pre", 32'(busy[0]), 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("mr_valid", 32'(valid[0]), 32'd0);
    checkOutput("mr_data", 32'(data0), 32'd0);
    checkOutput("mr_busy", 32'(busy[0]), 32'd0);
    rx_line[0] = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (2 * BIT) @(negedge clk);
    checkOutput("mr_novalid", 32'(valid[0]), 32'd0);
    applyStimulus(0, {6'd0, 1'b1, 8'hF0, 1'b0}, 10);
    waitValid(0, "mr2_valid");
    checkOutput("mr2_data", 32'(data0), 32'hF0);
    checkOutput("mr2_perr", 32'(pe[0]), 32'd0);
    checkOutput("mr2_ferr", 32'(fe[0]), 32'd0);
    ackWord(0, "mr2_ack");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
